// File: rtl/crc_pkg.sv
// Shared constants for the CRC accumulator: CRC width and FSM state encoding.
package crc_pkg;

    localparam int unsigned CRC_W = 32;

    // Legacy-compatible FSM encoding.
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE   = 1'b0;
    localparam state_t ST_IN_PKT = 1'b1;

endpackage

// File: rtl/crc_shift_mat.sv
// Combinational GF(2) matrix multiply that advances a CRC by one bus beat.
// Output bit i is the parity of the input masked by matrix row i.
module crc_shift_mat
    import crc_pkg::*;
#(
    parameter logic [1023:0] SHIFT_MATRIX = '0
) (
    input  logic [CRC_W-1:0] din,
    output logic [CRC_W-1:0] dout
);

    // One parity tree per output bit.
    always_comb begin
        dout = '0;
        for (int unsigned i = 0; i < CRC_W; i++) begin
            dout[i] = ^(din & SHIFT_MATRIX[i*CRC_W +: CRC_W]);
        end
    end

endmodule

// File: rtl/crc_accum_out.sv
// Per-packet CRC accumulator with result FIFO. Beats from the CRC pipe are
// folded into an accumulator; on eop the final CRC (with output XOR) is
// pushed into a small FIFO together with the mod and packet tag.
module crc_accum_out
    import crc_pkg::*;
#(
    parameter int unsigned   MOD_WIDTH    = 7,
    parameter logic [1023:0] SHIFT_MATRIX = '0,
    parameter logic [31:0]   CRC_XOROUT   = 32'hFFFFFFFF,
    parameter int unsigned   FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sop_in,
    input  logic                 eop_in,
    input  logic                 dval_in,
    input  logic [3:0]           packet_num_in,
    input  logic [MOD_WIDTH-1:0] mod_in,
    input  logic [CRC_W-1:0]     crc_in,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [CRC_W-1:0]     res_crc,
    output logic [MOD_WIDTH-1:0] res_mod,
    output logic [3:0]           res_packet_num,
    output logic                 err_orphan,
    output logic                 err_restart,
    output logic                 err_tag,
    output logic                 err_ovf,
    output logic [15:0]          pkt_cnt,
    output logic [15:0]          ovf_cnt
);

    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    state_t           state, state_nxt;
    logic [CRC_W-1:0] acc, acc_nxt, acc_shift, acc_step;
    logic [3:0]       tag, tag_nxt;

    logic                 push_req;
    logic [CRC_W-1:0]     push_crc;
    logic [MOD_WIDTH-1:0] push_mod;
    logic [3:0]           push_num;
    logic                 orphan_c, restart_c, tag_c;

    logic [CRC_W-1:0]     crc_mem [FIFO_DEPTH];
    logic [MOD_WIDTH-1:0] mod_mem [FIFO_DEPTH];
    logic [3:0]           num_mem [FIFO_DEPTH];
    logic [AW:0]          wptr, rptr;
    logic                 fifo_empty, fifo_full, pop, do_push, drop;

    crc_shift_mat #(
        .SHIFT_MATRIX(SHIFT_MATRIX)
    ) u_shift (
        .din  (acc),
        .dout (acc_shift)
    );

    assign acc_step = acc_shift ^ crc_in;

    // Beat decode: next state, accumulator update, push request and error flags.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        tag_nxt   = tag;
        push_req  = 1'b0;
        push_crc  = '0;
        push_mod  = '0;
        push_num  = '0;
        orphan_c  = 1'b0;
        restart_c = 1'b0;
        tag_c     = 1'b0;
        if (dval_in) begin
            if (sop_in) begin
                // A sop always starts a new packet; an open one is discarded.
                restart_c = (state == ST_IN_PKT);
                if (eop_in) begin
                    push_req  = 1'b1;
                    push_crc  = crc_in ^ CRC_XOROUT;
                    push_mod  = mod_in;
                    push_num  = packet_num_in;
                    state_nxt = ST_IDLE;
                end else begin
                    acc_nxt   = crc_in;
                    tag_nxt   = packet_num_in;
                    state_nxt = ST_IN_PKT;
                end
            end else if (state == ST_IDLE) begin
                orphan_c = 1'b1;
            end else begin
                tag_c   = (packet_num_in != tag);
                acc_nxt = acc_step;
                if (eop_in) begin
                    push_req  = 1'b1;
                    push_crc  = acc_step ^ CRC_XOROUT;
                    push_mod  = mod_in;
                    push_num  = tag;
                    state_nxt = ST_IDLE;
                end
            end
        end
    end

    // FSM, accumulator and tag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            acc   <= '0;
            tag   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            tag   <= tag_nxt;
        end
    end

    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop        = !fifo_empty && res_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push    = push_req && (!fifo_full || pop);
    assign drop       = push_req && fifo_full && !pop;

    // FIFO storage; cleared on reset so the head fields read zero when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                crc_mem[i] <= '0;
                mod_mem[i] <= '0;
                num_mem[i] <= '0;
            end
        end else if (do_push) begin
            crc_mem[wptr[AW-1:0]] <= push_crc;
            mod_mem[wptr[AW-1:0]] <= push_mod;
            num_mem[wptr[AW-1:0]] <= push_num;
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (pop)     rptr <= rptr + PTR_ONE;
        end
    end

    assign res_valid      = !fifo_empty;
    assign res_crc        = crc_mem[rptr[AW-1:0]];
    assign res_mod        = mod_mem[rptr[AW-1:0]];
    assign res_packet_num = num_mem[rptr[AW-1:0]];

    // Registered one-cycle error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_orphan  <= 1'b0;
            err_restart <= 1'b0;
            err_tag     <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            err_orphan  <= orphan_c;
            err_restart <= restart_c;
            err_tag     <= tag_c;
            err_ovf     <= drop;
        end
    end

    // Wrapping statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
            ovf_cnt <= '0;
        end else begin
            if (do_push) pkt_cnt <= pkt_cnt + 16'd1;
            if (drop)    ovf_cnt <= ovf_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_crc_accum_out.sv
// Scoreboard bench for crc_accum_out. Two instances share stimulus:
// dut_a uses an identity matrix with no output XOR, dut_b a rotate-right-by-1
// matrix with the default 0xFFFFFFFF output XOR.
module tb_crc_accum_out;

    typedef struct {
        logic [31:0] crc;
        logic [6:0]  mod;
        logic [3:0]  num;
    } entry_t;

    function automatic logic [1023:0] mk_ident();
        logic [1023:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) m[i*32 + i] = 1'b1;
        return m;
    endfunction

    function automatic logic [1023:0] mk_rotr();
        logic [1023:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) m[i*32 + ((i + 1) % 32)] = 1'b1;
        return m;
    endfunction

    localparam logic [1023:0] MAT_ID   = mk_ident();
    localparam logic [1023:0] MAT_ROTR = mk_rotr();

    logic        clk, rst_n;
    logic        sop_in, eop_in, dval_in, res_ready;
    logic [3:0]  packet_num_in;
    logic [6:0]  mod_in;
    logic [31:0] crc_in;

    logic        a_valid, a_orphan, a_restart, a_tag, a_ovf;
    logic [31:0] a_crc;
    logic [6:0]  a_mod;
    logic [3:0]  a_num;
    logic [15:0] a_pkt, a_ovfc;

    logic        b_valid, b_orphan, b_restart, b_tag, b_ovf;
    logic [31:0] b_crc;
    logic [6:0]  b_mod;
    logic [3:0]  b_num;
    logic [15:0] b_pkt, b_ovfc;

    int tests = 0;
    int fails = 0;
    int exp_pkt = 0;
    entry_t qa[$];
    entry_t qb[$];

    crc_accum_out #(
        .MOD_WIDTH(7), .SHIFT_MATRIX(MAT_ID), .CRC_XOROUT(32'h0), .FIFO_DEPTH(4)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .sop_in(sop_in), .eop_in(eop_in), .dval_in(dval_in),
        .packet_num_in(packet_num_in), .mod_in(mod_in), .crc_in(crc_in),
        .res_valid(a_valid), .res_ready(res_ready), .res_crc(a_crc), .res_mod(a_mod),
        .res_packet_num(a_num), .err_orphan(a_orphan), .err_restart(a_restart),
        .err_tag(a_tag), .err_ovf(a_ovf), .pkt_cnt(a_pkt), .ovf_cnt(a_ovfc)
    );

    crc_accum_out #(
        .MOD_WIDTH(7), .SHIFT_MATRIX(MAT_ROTR), .CRC_XOROUT(32'hFFFFFFFF), .FIFO_DEPTH(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .sop_in(sop_in), .eop_in(eop_in), .dval_in(dval_in),
        .packet_num_in(packet_num_in), .mod_in(mod_in), .crc_in(crc_in),
        .res_valid(b_valid), .res_ready(res_ready), .res_crc(b_crc), .res_mod(b_mod),
        .res_packet_num(b_num), .err_orphan(b_orphan), .err_restart(b_restart),
        .err_tag(b_tag), .err_ovf(b_ovf), .pkt_cnt(b_pkt), .ovf_cnt(b_ovfc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor for dut_a: compare each accepted result with the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && a_valid && res_ready) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_result", 32'd1, 32'd0);
            end else begin
                entry_t e;
                e = qa.pop_front();
                chk("a_res_crc", a_crc, e.crc);
                chk("a_res_mod", {25'd0, a_mod}, {25'd0, e.mod});
                chk("a_res_num", {28'd0, a_num}, {28'd0, e.num});
            end
        end
    end

    // Monitor for dut_b.
    always @(negedge clk) begin
        if (rst_n && b_valid && res_ready) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_result", 32'd1, 32'd0);
            end else begin
                entry_t e;
                e = qb.pop_front();
                chk("b_res_crc", b_crc, e.crc);
                chk("b_res_mod", {25'd0, b_mod}, {25'd0, e.mod});
                chk("b_res_num", {28'd0, b_num}, {28'd0, e.num});
            end
        end
    end

    task automatic expect_push(input logic [31:0] ca, input logic [31:0] cb,
                               input logic [6:0] m, input logic [3:0] n);
        entry_t e;
        e.mod = m;
        e.num = n;
        e.crc = ca;
        qa.push_back(e);
        e.crc = cb;
        qb.push_back(e);
        exp_pkt++;
    endtask

    // One valid beat, sampled on the next rising edge; returns 1 time unit after it.
    task automatic beat(input logic s, input logic e, input logic [3:0] n,
                        input logic [6:0] m, input logic [31:0] c);
        sop_in = s; eop_in = e; dval_in = 1'b1;
        packet_num_in = n; mod_in = m; crc_in = c;
        @(posedge clk);
        #1;
        sop_in = 1'b0; eop_in = 1'b0; dval_in = 1'b0;
        packet_num_in = 4'hF; mod_in = 7'h7F; crc_in = 32'hA5A5A5A5;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && (qa.size() != 0 || qb.size() != 0); i++) idle(1);
        chk("drain_pending", qa.size() + qb.size(), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; res_ready = 1'b1;
        sop_in = 1'b0; eop_in = 1'b0; dval_in = 1'b0;
        packet_num_in = '0; mod_in = '0; crc_in = '0;
        idle(2);

        // Reset state
        chk("rst_valid", {31'd0, a_valid | b_valid}, 32'd0);
        chk("rst_crc", a_crc | b_crc, 32'd0);
        chk("rst_err", {28'd0, a_orphan, a_restart, a_tag, a_ovf}, 32'd0);
        chk("rst_cnt", {a_pkt, a_ovfc}, 32'd0);
        rst_n = 1'b1;
        idle(1);

        // Three-beat packet with a dval gap in the middle
        beat(1'b1, 1'b0, 4'd7, 7'd0, 32'h11111111);
        idle(1);
        beat(1'b0, 1'b0, 4'd7, 7'd0, 32'h22222222);
        chk("pre_eop_valid", {31'd0, a_valid}, 32'd0);
        expect_push(32'h77777777, 32'hEEEEEEEE, 7'd3, 4'd7);
        beat(1'b0, 1'b1, 4'd7, 7'd3, 32'h44444444);
        chk("eop_latency_valid", {31'd0, a_valid}, 32'd1);
        chk("multi_no_err", {28'd0, b_orphan, b_restart, b_tag, b_ovf}, 32'd0);
        wait_drain();

        // Single-beat packet
        expect_push(32'hDEADBEEF, 32'h21524110, 7'd9, 4'd4);
        beat(1'b1, 1'b1, 4'd4, 7'd9, 32'hDEADBEEF);
        wait_drain();

        // Tag mismatch mid-packet: flagged, accumulation continues with latched tag
        beat(1'b1, 1'b0, 4'd1, 7'd0, 32'h00000001);
        beat(1'b0, 1'b0, 4'd3, 7'd0, 32'h00000010);
        chk("err_tag", {31'd0, a_tag & b_tag}, 32'd1);
        expect_push(32'h00000111, 32'hBFFFFEF7, 7'd5, 4'd1);
        beat(1'b0, 1'b1, 4'd1, 7'd5, 32'h00000100);
        chk("err_tag_clear", {31'd0, a_tag}, 32'd0);
        wait_drain();

        // Orphan eop in IDLE
        beat(1'b0, 1'b1, 4'd2, 7'd1, 32'h12345678);
        chk("orphan_pulse", {31'd0, a_orphan & b_orphan}, 32'd1);
        chk("orphan_no_valid", {31'd0, a_valid | b_valid}, 32'd0);
        idle(1);
        chk("orphan_pkt_cnt", {16'd0, a_pkt}, exp_pkt);

        // Restart: sop(tag 2) then sop+eop(tag 5)
        beat(1'b1, 1'b0, 4'd2, 7'd0, 32'hCAFEF00D);
        expect_push(32'h12345678, 32'hEDCBA987, 7'd1, 4'd5);
        beat(1'b1, 1'b1, 4'd5, 7'd1, 32'h12345678);
        chk("restart_pulse", {31'd0, a_restart & b_restart}, 32'd1);
        wait_drain();

        // Overflow: hold ready low, push 5 single-beat packets
        res_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            logic [31:0] c;
            c = {4{k[7:0]}};
            if (k <= 4) expect_push(c, ~c, k[6:0], k[3:0]);
            beat(1'b1, 1'b1, k[3:0], k[6:0], c);
            chk("ovf_pulse", {31'd0, a_ovf}, (k == 5) ? 32'd1 : 32'd0);
        end
        chk("b_ovf_pulse", {31'd0, b_ovf}, 32'd1);
        chk("ovf_cnt", {16'd0, a_ovfc}, 32'd1);
        chk("pkt_cnt_full", {16'd0, a_pkt}, exp_pkt);
        idle(3);
        chk("hold_crc_stable", a_crc, 32'h01010101);
        chk("hold_b_crc_stable", b_crc, 32'hFEFEFEFE);
        // Push while full with a simultaneous pop is accepted
        res_ready = 1'b1;
        expect_push(32'h06060606, 32'hF9F9F9F9, 7'd6, 4'd6);
        beat(1'b1, 1'b1, 4'd6, 7'd6, 32'h06060606);
        chk("full_pushpop_no_ovf", {31'd0, a_ovf | b_ovf}, 32'd0);
        chk("full_pushpop_pkt", {16'd0, b_pkt}, exp_pkt);
        chk("ovf_cnt_hold", {16'd0, b_ovfc}, 32'd1);
        wait_drain();

        // Reset in mid-packet
        beat(1'b1, 1'b0, 4'd3, 7'd0, 32'h0F0F0F0F);
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        exp_pkt = 0;
        chk("midrst_valid", {31'd0, a_valid | b_valid}, 32'd0);
        chk("midrst_cnt", {16'd0, a_pkt}, 32'd0);
        @(posedge clk);
        #1;
        beat(1'b0, 1'b1, 4'd3, 7'd2, 32'hF0F0F0F0);
        chk("midrst_orphan", {31'd0, a_orphan & b_orphan}, 32'd1);
        chk("midrst_no_push", {31'd0, a_valid | b_valid}, 32'd0);
        idle(2);
        chk("midrst_pkt_cnt", {16'd0, b_pkt}, exp_pkt);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
